// File: rtl/cache_refill_ctrl.sv
// Load-miss line refill and write-through store controller between the M-stage
// direct-mapped data cache and data memory.
module cache_refill_ctrl #(
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [31:0]       WriteDataM,
  input  logic              Hit,
  output logic              StallM,
  output logic [31:0]       ReadDataM,
  output logic              ReadValidM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              FillEn,
  output logic [ADDR_W-1:0] FillAddr,
  output logic [31:0]       FillData,
  output logic              FillLast
);
  localparam int LINE_BYTES = 4 * WORDS_PER_LINE;
  localparam int CW         = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] IDX_MASK  = ADDR_W'(WORDS_PER_LINE - 1);
  localparam logic [CW-1:0]     LAST      = CW'(WORDS_PER_LINE - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WRITE  = 2'd1;
  localparam logic [1:0] REFILL = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;   // word address for a store, line base for a refill
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     idx_q;
  logic [ADDR_W-1:0] fill_addr;
  logic              miss;
  logic              beat;

  assign miss      = MemReadM & ~Hit;
  assign beat      = (state == REFILL) & mem_ack;
  assign fill_addr = addr_q | (ADDR_W'(cnt) << 2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
      idx_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // a store takes priority over a simultaneous load miss
          if (MemWriteM) begin
            addr_q  <= ALUResultM & WORD_MASK;
            wdata_q <= WriteDataM;
            state   <= WRITE;
          end else if (miss) begin
            addr_q <= ALUResultM & LINE_MASK;
            idx_q  <= CW'((ALUResultM >> 2) & IDX_MASK);
            cnt    <= '0;
            state  <= REFILL;
          end
        end
        WRITE: if (mem_ack) state <= IDLE;
        REFILL: begin
          if (mem_ack) begin
            if (cnt == idx_q) rdata_q <= mem_rdata;
            cnt <= cnt + CW'(1);
            if (cnt == LAST) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // stall is released on the store ack cycle and in DONE; reset forces it low
  always_comb begin
    StallM = 1'b0;
    case (state)
      IDLE:    StallM = MemWriteM | miss;
      WRITE:   StallM = ~mem_ack;
      REFILL:  StallM = 1'b1;
      default: StallM = 1'b0;
    endcase
    StallM = StallM & rst;
  end

  assign mem_req    = (state == WRITE) | (state == REFILL);
  assign mem_we     = (state == WRITE);
  assign mem_addr   = (state == WRITE) ? addr_q : (state == REFILL) ? fill_addr : '0;
  assign mem_wdata  = mem_we ? wdata_q : '0;
  assign FillEn     = beat;
  assign FillAddr   = beat ? fill_addr : '0;
  assign FillData   = beat ? mem_rdata : '0;
  assign FillLast   = beat & (cnt == LAST);
  assign ReadDataM  = rdata_q;
  assign ReadValidM = (state == DONE);
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: directed table, reset-mid-refill sequence and
// random loads/stores against a transaction-level expectation model.
module tb_cache_refill_ctrl;
  localparam int WPL = 4;
  localparam int LB  = 4 * WPL;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM, Hit;
  logic [31:0] ALUResultM, WriteDataM;
  logic        StallM, ReadValidM;
  logic [31:0] ReadDataM;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        FillEn, FillLast;
  logic [31:0] FillAddr, FillData;

  cache_refill_ctrl #(.WORDS_PER_LINE(WPL), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .Hit(Hit),
    .StallM(StallM), .ReadDataM(ReadDataM), .ReadValidM(ReadValidM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .FillEn(FillEn), .FillAddr(FillAddr),
    .FillData(FillData), .FillLast(FillLast)
  );

  always #5 clk = ~clk;

  // memory contents: word at address A reads as A ^ key
  logic [31:0] key;
  assign mem_rdata = mem_addr ^ key;

  int checks = 0, failures = 0;
  int delay = 0, w = 0;
  bit noise = 0;

  int o_stall, o_fills, o_rv, o_wr, o_req, o_cyc;
  logic [31:0] o_rd, o_wa, o_wd;
  bit o_ferr, o_serr, o_to, o_idle_req, o_idle_stall;

  typedef struct {
    int          op;      // 0 load, 1 store, 2 load+store together
    logic [31:0] a;
    logic [31:0] wd;
    bit          hit;
    int          d;
    int          exp_stall;
    int          exp_fills;
    logic [31:0] exp_rd;
    logic [31:0] exp_wa;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // memory responder, called once per cycle at the falling edge
  task automatic respond();
    if (mem_ack || !mem_req) w = 0;
    if (mem_req) begin
      if (w >= delay) mem_ack = 1'b1;
      else begin mem_ack = 1'b0; w++; end
    end else begin
      mem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_ctrl"}, {58'd0, StallM, ReadValidM, mem_req, mem_we, FillEn, FillLast}, 64'd0);
    chk({p, "_rdata"}, ReadDataM, 0);
    chk({p, "_maddr"}, mem_addr, 0);
    chk({p, "_mwdata"}, mem_wdata, 0);
    chk({p, "_faddr"}, FillAddr, 0);
    chk({p, "_fdata"}, FillData, 0);
  endtask

  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] wd,
                        input bit hit, input int d);
    logic [31:0] base, pa, pd;
    bit pw, done;
    base = a & ~32'(LB - 1);
    delay = d;
    o_stall = 0; o_fills = 0; o_rv = 0; o_wr = 0; o_req = 0; o_cyc = 0;
    o_rd = 0; o_wa = 0; o_wd = 0; o_ferr = 0; o_serr = 0; o_to = 0;
    pw = 0; pa = 0; pd = 0; done = 0;
    @(negedge clk);
    MemReadM = (op != 1); MemWriteM = (op != 0); ALUResultM = a; WriteDataM = wd; Hit = hit;
    while (!done) begin
      respond(); #1;
      if (StallM) o_stall++;
      if (mem_req) o_req++;
      if (pw && mem_req && (mem_addr !== pa || mem_wdata !== pd)) o_serr = 1;
      pw = mem_req && !mem_ack; pa = mem_addr; pd = mem_wdata;
      if (FillEn) begin
        if (FillAddr !== base + 32'(4 * o_fills) || FillData !== (FillAddr ^ key) ||
            FillLast !== (o_fills == WPL - 1) || mem_we) o_ferr = 1;
        o_fills++;
      end
      if (mem_req && mem_we && mem_ack) begin o_wr++; o_wa = mem_addr; o_wd = mem_wdata; end
      if (ReadValidM) begin o_rv++; o_rd = ReadDataM; end
      o_cyc++;
      if (o_cyc >= 500) begin o_to = 1; done = 1; end
      else if (!StallM) done = 1;
      else @(negedge clk);
    end
    @(negedge clk);
    MemReadM = 0; MemWriteM = 0; Hit = 0;
    respond(); #1;
    o_idle_req = mem_req; o_idle_stall = StallM;
  endtask

  // expected behaviour of one pipeline operation, from the handshake rules
  task automatic check_model(input int op, input logic [31:0] a, input logic [31:0] wd,
                             input bit hit, input int d);
    bit st, ms;
    st = (op != 0);
    ms = !st && !hit;
    chk("timeout", o_to, 0);
    chk("stall_cycles", o_stall, st ? 1 + d : ms ? 1 + WPL * (d + 1) : 0);
    chk("req_cycles", o_req, st ? d + 1 : ms ? WPL * (d + 1) : 0);
    chk("fill_beats", o_fills, ms ? WPL : 0);
    chk("fill_seq", o_ferr, 0);
    chk("read_valid", o_rv, ms ? 1 : 0);
    if (ms) chk("read_data", o_rd, (a & ~32'h3) ^ key);
    chk("writes", o_wr, st ? 1 : 0);
    if (st) begin
      chk("wr_addr", o_wa, a & ~32'h3);
      chk("wr_data", o_wd, wd);
    end
    chk("req_stable", o_serr, 0);
    chk("idle_after", {o_idle_req, o_idle_stall}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit lastseen;
    int beats;
    tbl[0] = '{0, 32'h0000_1048, 32'h0,         1'b0, 0, 5,  4, 32'h0000_1048, 32'h0};
    tbl[1] = '{0, 32'h0000_1048, 32'h0,         1'b0, 3, 17, 4, 32'h0000_1048, 32'h0};
    tbl[2] = '{1, 32'h0000_2003, 32'hDEADBEEF,  1'b0, 2, 3,  0, 32'h0,         32'h0000_2000};
    tbl[3] = '{0, 32'h0000_3000, 32'h0,         1'b1, 0, 0,  0, 32'h0,         32'h0};
    tbl[4] = '{2, 32'h0000_4006, 32'h1234_5678, 1'b0, 1, 2,  0, 32'h0,         32'h0000_4004};
    tbl[5] = '{0, 32'hFFFF_FFF6, 32'h0,         1'b0, 0, 5,  4, 32'hFFFF_FFF4, 32'h0};

    key = 0; mem_ack = 0;
    rst = 0; MemReadM = 1; MemWriteM = 1; Hit = 0; ALUResultM = 32'h1048; WriteDataM = 32'h55;
    #3;
    chk_zero("por");
    @(negedge clk); MemReadM = 0; MemWriteM = 0;
    @(negedge clk); rst = 1;

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].wd, tbl[i].hit, tbl[i].d);
      chk($sformatf("vec%0d_stall", i), o_stall, tbl[i].exp_stall);
      chk($sformatf("vec%0d_fills", i), o_fills, tbl[i].exp_fills);
      if (tbl[i].exp_fills != 0) chk($sformatf("vec%0d_rdata", i), o_rd, tbl[i].exp_rd);
      if (tbl[i].op != 0) chk($sformatf("vec%0d_waddr", i), o_wa, tbl[i].exp_wa);
      check_model(tbl[i].op, tbl[i].a, tbl[i].wd, tbl[i].hit, tbl[i].d);
    end

    // reset lands after the second fill beat of a refill
    delay = 0; beats = 0; lastseen = 0;
    @(negedge clk);
    MemReadM = 1; MemWriteM = 0; Hit = 0; ALUResultM = 32'h1048;
    for (int i = 0; i < 20 && beats < 2; i++) begin
      respond(); #1;
      if (FillEn) beats++;
      if (FillLast) lastseen = 1;
      if (beats < 2) @(negedge clk);
    end
    chk("rst_mid_beats", beats, 2);
    @(posedge clk); #2;
    rst = 0; #1;
    chk_zero("rst_mid");
    chk("rst_mid_nolast", lastseen, 0);
    @(negedge clk); MemReadM = 0; respond();
    @(negedge clk); rst = 1;
    run_op(0, 32'h1048, 0, 1'b0, 0);
    check_model(0, 32'h1048, 0, 1'b0, 0);

    noise = 1;
    for (int i = 0; i < 40; i++) begin
      int op, d;
      bit h;
      logic [31:0] a, wd;
      op = $urandom_range(0, 3);
      if (op == 3) op = 0;
      h = 1'($urandom_range(0, 1));
      d = $urandom_range(0, 3);
      a = $urandom; wd = $urandom; key = $urandom;
      run_op(op, a, wd, h, d);
      check_model(op, a, wd, h, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
